// File: rtl/cq_viola_rst_pkg.sv
// Shared reset-sequencer types: one-hot FSM encodings and debug counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cq_viola_rst_pkg;

    // One-hot encodings; any other pattern is treated as illegal and recovers to ASSERT.
    typedef enum logic [3:0] {
        ST_ASSERT = 4'b0001,
        ST_HOLD   = 4'b0010,
        ST_SETTLE = 4'b0100,
        ST_RUN    = 4'b1000
    } rst_state_t;

    localparam int RST_COUNT_W = 8;

    // Larger of two elaboration-time integers, used to size shared down-counters.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cq_viola_sync_ff.sv
// Multi-flop level synchroniser with selectable reset value.
// Latency: DEPTH clk edges from d_i to q_o.
// Backpressure: none; free-running level path.
module cq_viola_sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift the asynchronous level through the chain; bit 0 is the metastable capture flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/cq_viola_cpu_reset_sequencer.sv
// Turns the PIO reset-request level into a min-width, glitch-free reset for the secondary CPU.
// Latency: request -> target_reset_n low after SYNC_STAGES edges; release adds SETTLE_CYCLES to running.
// Backpressure: none; low width is at least HOLD_CYCLES+1 regardless of request width.
module cq_viola_cpu_reset_sequencer
    import cq_viola_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   reset_req,
    output logic                   target_reset_n,
    output logic                   running,
    output logic [RST_COUNT_W-1:0] rst_count
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RST_COUNT_W-1:0] COUNT_SAT = {RST_COUNT_W{1'b1}};

    generate
        if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_params
            $error("cq_viola_cpu_reset_sequencer: illegal SYNC_STAGES/HOLD_CYCLES/SETTLE_CYCLES");
        end
    endgenerate

    logic                   req_s;
    rst_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tgt_rst_n_q, tgt_rst_n_d;
    logic                   running_q, running_d;
    logic [RST_COUNT_W-1:0] rst_count_q, rst_count_d;
    logic                   sw_reset;

    // Synchroniser resets to 1 so every power-on looks like a held request and runs the full sequence.
    cq_viola_sync_ff #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (reset_req),
        .q_o     (req_s)
    );

    // Next-state, counter and registered-output decode; outputs follow the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sw_reset    = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                cnt_d   = HOLD_LOAD;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!req_s) begin
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (req_s) begin
                    sw_reset = 1'b1;
                    state_d  = ST_ASSERT;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (req_s) begin
                    sw_reset = 1'b1;
                    state_d  = ST_ASSERT;
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        tgt_rst_n_d = (state_d == ST_SETTLE) || (state_d == ST_RUN);
        running_d   = (state_d == ST_RUN);

        rst_count_d = rst_count_q;
        if (sw_reset && (rst_count_q != COUNT_SAT)) begin
            rst_count_d = rst_count_q + 1'b1;
        end
    end

    // State, counter and output registers; reset drives the target into reset without a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            tgt_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            rst_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_rst_n_q <= tgt_rst_n_d;
            running_q   <= running_d;
            rst_count_q <= rst_count_d;
        end
    end

    assign target_reset_n = tgt_rst_n_q;
    assign running        = running_q;
    assign rst_count      = rst_count_q;

endmodule

// File: tb/tb_cq_viola_cpu_reset_sequencer.sv
// Directed bench for the CPU reset sequencer with default parameters.
// Latency: checks every edge of each sequence against hand-derived edge counts.
// Backpressure: n/a.
module tb_cq_viola_cpu_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       reset_req;
    logic       target_reset_n;
    logic       running;
    logic [7:0] rst_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cq_viola_cpu_reset_sequencer #(
        .SYNC_STAGES   (2),
        .HOLD_CYCLES   (16),
        .SETTLE_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .reset_req      (reset_req),
        .target_reset_n (target_reset_n),
        .running        (running),
        .rst_count      (rst_count)
    );

    // Reset held 5 cycles, released between edges; low for 17 edges, running 8 edges later.
    task automatic test_power_on(input string tag);
        reset_n   = 1'b0;
        reset_req = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (target_reset_n !== 1'b0 || running !== 1'b0 || rst_count !== 8'd0) begin
            miscompares++;
            $display("FAIL %s in_reset: got trn=%b run=%b cnt=%0d want 0/0/0",
                     tag, target_reset_n, running, rst_count);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            vectors++;
            if (target_reset_n !== (k >= 17) || running !== (k >= 25)) begin
                miscompares++;
                $display("FAIL %s edge %0d: got trn=%b run=%b want %b/%b",
                         tag, k, target_reset_n, running, k >= 17, k >= 25);
            end
        end
        vectors++;
        if (rst_count !== 8'd0) begin
            miscompares++;
            $display("FAIL %s count: got %0d want 0", tag, rst_count);
        end
    endtask

    // One-cycle request from RUN: low after edge 2 for exactly 17 cycles.
    task automatic test_single_pulse();
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            vectors++;
            if (target_reset_n !== !(k >= 2 && k < 19) || running !== (k < 2 || k >= 27)) begin
                miscompares++;
                $display("FAIL pulse edge %0d: got trn=%b run=%b want %b/%b",
                         k, target_reset_n, running, !(k >= 2 && k < 19), (k < 2 || k >= 27));
            end
        end
        vectors++;
        if (rst_count !== 8'd1) begin
            miscompares++;
            $display("FAIL pulse count: got %0d want 1", rst_count);
        end
    endtask

    // 100-cycle request: held in reset until 2 edges after release, running 8 later.
    task automatic test_long_request();
        reset_req = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            vectors++;
            if (target_reset_n !== (k < 2) || running !== (k < 2)) begin
                miscompares++;
                $display("FAIL long_hold edge %0d: got trn=%b run=%b want %b/%b",
                         k, target_reset_n, running, k < 2, k < 2);
            end
        end
        reset_req = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            vectors++;
            if (target_reset_n !== (j >= 2) || running !== (j >= 10)) begin
                miscompares++;
                $display("FAIL long_release edge %0d: got trn=%b run=%b want %b/%b",
                         j, target_reset_n, running, j >= 2, j >= 10);
            end
        end
        vectors++;
        if (rst_count !== 8'd2) begin
            miscompares++;
            $display("FAIL long count: got %0d want 2", rst_count);
        end
    endtask

    // Pulse from RUN, then re-request during SETTLE: second full hold, running stays low.
    task automatic test_settle_reassert();
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            vectors++;
            if (target_reset_n !== !((k >= 2 && k < 19) || (k >= 24 && k < 41)) ||
                running !== (k < 2 || k >= 49)) begin
                miscompares++;
                $display("FAIL settle edge %0d: got trn=%b run=%b want %b/%b", k,
                         target_reset_n, running,
                         !((k >= 2 && k < 19) || (k >= 24 && k < 41)), (k < 2 || k >= 49));
            end
            if (k == 21) reset_req = 1'b1;
            if (k == 22) reset_req = 1'b0;
        end
        vectors++;
        if (rst_count !== 8'd4) begin
            miscompares++;
            $display("FAIL settle count: got %0d want 4", rst_count);
        end
    endtask

    // 300 back-to-back requests, each landing in SETTLE: count saturates at 255.
    task automatic test_saturation();
        int t;
        bit timed_out;
        timed_out = 1'b0;
        for (int i = 0; i < 300 && !timed_out; i++) begin
            reset_req = 1'b1;
            @(negedge clk);
            reset_req = 1'b0;
            t = 0;
            while (target_reset_n !== 1'b0 && t < 10) begin
                @(negedge clk);
                t++;
            end
            t = 0;
            while (target_reset_n !== 1'b1 && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) begin
                timed_out = 1'b1;
                vectors++;
                miscompares++;
                $display("FAIL sat timeout at pulse %0d: trn=%b want 1", i, target_reset_n);
            end
            if (i == 250) begin
                vectors++;
                if (rst_count !== 8'd255) begin
                    miscompares++;
                    $display("FAIL sat reach: got %0d want 255", rst_count);
                end
            end
        end
        vectors++;
        if (rst_count !== 8'd255) begin
            miscompares++;
            $display("FAIL sat hold: got %0d want 255", rst_count);
        end
    endtask

    // reset_n dropped mid-HOLD and mid-RUN: outputs clear before any clock edge.
    task automatic test_async_reset();
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        repeat (6) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (target_reset_n !== 1'b0 || running !== 1'b0 || rst_count !== 8'd0) begin
            miscompares++;
            $display("FAIL async_hold: got trn=%b run=%b cnt=%0d want 0/0/0",
                     target_reset_n, running, rst_count);
        end
        test_power_on("repower_hold");
        @(negedge clk);
        vectors++;
        if (target_reset_n !== 1'b1 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_async_run: got trn=%b run=%b want 1/1", target_reset_n, running);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (target_reset_n !== 1'b0 || running !== 1'b0 || rst_count !== 8'd0) begin
            miscompares++;
            $display("FAIL async_run: got trn=%b run=%b cnt=%0d want 0/0/0",
                     target_reset_n, running, rst_count);
        end
        test_power_on("repower_run");
    endtask

    initial begin
        reset_n   = 1'b0;
        reset_req = 1'b0;
        test_power_on("power_on");
        test_single_pulse();
        test_long_request();
        test_settle_reassert();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
